// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shifter: a one-word holding buffer feeds a WIDTH-bit
// serializer that emits LSB first, one bit per enabled cycle, with gapless back-to-back words.
module piso_shift_register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             word_start,
  output logic             word_end
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_hold, w_hold_d;
  logic [WIDTH-1:0] r_shreg, w_shreg_d;
  logic             r_hold_full, w_hold_full_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             w_accept;
  logic             w_last;
  logic             w_load;

  assign w_accept = in_valid && !r_hold_full;
  assign w_last   = (r_cnt == CntLast);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_shreg_d = r_shreg;
    w_load    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_hold_full) begin
          w_load    = 1'b1;
          w_state_d = StShift;
        end
      end
      StShift: begin
        if (enable) begin
          if (!w_last) begin
            w_shreg_d = {1'b0, r_shreg[WIDTH-1:1]};
            w_cnt_d   = r_cnt + 1'b1;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_load) begin
      w_shreg_d = r_hold;
      w_cnt_d   = '0;
    end
    // in_ready is low whenever a load happens, so accept and transfer never collide.
    w_hold_d      = w_accept ? in : r_hold;
    w_hold_full_d = w_accept || (r_hold_full && !w_load);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_hold      <= w_hold_d;
      r_hold_full <= w_hold_full_d;
      r_shreg     <= w_shreg_d;
      r_cnt       <= w_cnt_d;
    end
  end

  assign in_ready   = !r_hold_full;
  assign out_valid  = (r_state == StShift);
  assign out        = out_valid && r_shreg[0];
  assign word_start = out_valid && (r_cnt == '0);
  assign word_end   = out_valid && w_last;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed plus random bench for piso_shift_register at WIDTH 8, 2 and 256; expected
// serial bits are queued on acceptance and compared as the serializer emits them.
module tb_piso_shift_register;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       en8, v8, rdy8, o8, ov8, ws8, we8;
  logic [7:0] in8;
  logic       en_s;
  logic       v2, rdy2, o2, ov2, ws2, we2;
  logic [1:0] w2;
  logic         v256, rdy256, o256, ov256, ws256, we256;
  logic [255:0] w256;

  int n_vec = 0;
  int n_err = 0;
  int run8 = 0;
  int last_run8 = 0;

  // Each entry: {word_start, word_end, bit}
  logic [2:0] q8[$];
  logic [2:0] q2[$];
  logic [2:0] q256[$];

  piso_shift_register #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rstn(rstn), .enable(en8), .in(in8), .in_valid(v8), .in_ready(rdy8),
    .out(o8), .out_valid(ov8), .word_start(ws8), .word_end(we8)
  );
  piso_shift_register #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .enable(en_s), .in(w2), .in_valid(v2), .in_ready(rdy2),
    .out(o2), .out_valid(ov2), .word_start(ws2), .word_end(we2)
  );
  piso_shift_register #(.WIDTH(256)) u_dut256 (
    .clk(clk), .rstn(rstn), .enable(en_s), .in(w256), .in_valid(v256), .in_ready(rdy256),
    .out(o256), .out_valid(ov256), .word_start(ws256), .word_end(we256)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int which, input logic [255:0] w, input int width);
    for (int i = 0; i < width; i++) begin
      case (which)
        0:       q8.push_back({i == 0, i == width - 1, w[i]});
        1:       q2.push_back({i == 0, i == width - 1, w[i]});
        default: q256.push_back({i == 0, i == width - 1, w[i]});
      endcase
    end
  endtask

  task automatic mon(input int which, input logic ov, input logic o, input logic ws,
                     input logic we, input logic en);
    logic [2:0] e;
    int         sz;
    if (!ov) begin
      chk($sformatf("idle outputs dut%0d", which), {29'b0, ws, we, o}, 32'd0);
    end else begin
      case (which)
        0:       sz = q8.size();
        1:       sz = q2.size();
        default: sz = q256.size();
      endcase
      if (sz == 0) begin
        chk($sformatf("unexpected out_valid dut%0d", which), {31'b0, ov}, 32'd0);
      end else begin
        case (which)
          0:       begin e = q8[0];   if (en) void'(q8.pop_front());   end
          1:       begin e = q2[0];   if (en) void'(q2.pop_front());   end
          default: begin e = q256[0]; if (en) void'(q256.pop_front()); end
        endcase
        chk($sformatf("serial {start,end,bit} dut%0d", which), {29'b0, ws, we, o},
            {29'b0, e});
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    mon(0, ov8, o8, ws8, we8, en8);
    mon(1, ov2, o2, ws2, we2, en_s);
    mon(2, ov256, o256, ws256, we256, en_s);
    if (ov8) run8++;
    else if (run8 != 0) begin
      last_run8 = run8;
      run8 = 0;
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge, in_valid left high.
  task automatic send8(input logic [7:0] w, output int waited);
    waited = 0;
    in8 = w;
    v8 = 1'b1;
    while (!rdy8 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("send8 accepted", {31'b0, rdy8}, 32'd1);
    push(0, {248'b0, w}, 8);
    @(negedge clk);
  endtask

  task automatic wait_idle8();
    int t = 0;
    while ((ov8 || q8.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("dut8 drained", q8.size(), 32'd0);
    chk("dut8 back to idle", {31'b0, ov8}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int t;
    int n2acc = 0;
    int n256acc = 0;
    rstn = 1'b0; en8 = 1'b1; v8 = 1'b0; in8 = '0;
    en_s = 1'b1; v2 = 1'b0; w2 = '0; v256 = 1'b0; w256 = '0;
    #2;
    chk("reset in_ready", {29'b0, rdy8, rdy2, rdy256}, 32'd7);
    chk("reset out_valid", {29'b0, ov8, ov2, ov256}, 32'd0);
    chk("reset out/start/end", {29'b0, o8, ws8, we8}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);

    // Single word, one-cycle hold then serial start.
    send8(8'hA5, t);
    v8 = 1'b0;
    chk("A5 hold full in_ready", {31'b0, rdy8}, 32'd0);
    chk("A5 not yet valid", {31'b0, ov8}, 32'd0);
    @(negedge clk);
    chk("A5 out_valid", {31'b0, ov8}, 32'd1);
    chk("A5 word_start", {31'b0, ws8}, 32'd1);
    chk("A5 in_ready after load", {31'b0, rdy8}, 32'd1);
    wait_idle8();
    chk("A5 valid run", last_run8, 32'd8);

    // Back-to-back words with in_valid held.
    send8(8'h01, t);
    send8(8'h80, t);
    chk("0x80 accept wait", t, 32'd1);
    v8 = 1'b0;
    wait_idle8();
    chk("01/80 gapless run", last_run8, 32'd16);

    // Enable toggling holds each bit.
    send8(8'h3C, t);
    v8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en8 = (i % 2 == 0);
    end
    en8 = 1'b1;
    wait_idle8();

    // Shreg and hold both full: third word waits for the transfer.
    send8(8'h11, t);
    send8(8'h22, t);
    chk("in_ready low both full", {31'b0, rdy8}, 32'd0);
    send8(8'h33, t);
    chk("third word accept wait", t, 32'd7);
    v8 = 1'b0;
    wait_idle8();
    chk("three word gapless run", last_run8, 32'd24);

    // Asynchronous reset mid-word with hold full.
    send8(8'hFF, t);
    send8(8'hAA, t);
    v8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("FF bit3 visible", {30'b0, ov8, o8}, 32'd3);
    #2 rstn = 1'b0;
    #1;
    chk("async reset in_ready", {31'b0, rdy8}, 32'd1);
    chk("async reset outputs", {28'b0, ov8, o8, ws8, we8}, 32'd0);
    q8.delete();
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    chk("post reset idle", {30'b0, ov8, rdy8}, 32'd1);
    @(negedge clk);
    chk("post reset no residue", {31'b0, ov8}, 32'd0);
    send8(8'h00, t);
    v8 = 1'b0;
    wait_idle8();
    chk("00 run after reset", last_run8, 32'd8);

    // Random smoke on WIDTH=2 and WIDTH=256 with random enable.
    for (int c = 0; c < 3000; c++) begin
      en_s = ($urandom_range(0, 3) != 0);
      v2 = (n2acc < 60) && ($urandom_range(0, 1) == 1);
      w2 = 2'($urandom);
      if (v2 && rdy2) begin
        push(1, {254'b0, w2}, 2);
        n2acc++;
      end
      v256 = (n256acc < 6) && ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 8; k++) w256[k*32 +: 32] = $urandom;
      if (v256 && rdy256) begin
        push(2, w256, 256);
        n256acc++;
      end
      @(negedge clk);
    end
    v2 = 1'b0; v256 = 1'b0; en_s = 1'b1;
    t = 0;
    while ((ov2 || ov256 || q2.size() != 0 || q256.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("dut2 drained", q2.size(), 32'd0);
    chk("dut256 drained", q256.size(), 32'd0);
    chk("dut256 words accepted", n256acc, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
